// File: rtl/glb_dma_hdr_agen_pkg.sv
// ============================================================================
// glb_dma_hdr_agen_pkg : shared types for the GLB DMA header address generator
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package glb_dma_hdr_agen_pkg;

    localparam int GLB_ADDR_WIDTH      = 22;
    localparam int MAX_NUM_WORDS_WIDTH = 21;
    localparam int GLB_BANK_DATA_WIDTH = 64;
    localparam int GLB_CGRA_DATA_WIDTH = 16;
    localparam int BEAT_BYTES          = GLB_BANK_DATA_WIDTH / 8;
    localparam int WORDS_PER_BEAT      = GLB_BANK_DATA_WIDTH / GLB_CGRA_DATA_WIDTH;

    typedef struct packed {
        logic                           valid;
        logic [GLB_ADDR_WIDTH-1:0]      start_addr;
        logic [MAX_NUM_WORDS_WIDTH-1:0] num_words;
    } dma_header_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        NEXT   = 2'd3
    } dma_agen_state_e;

    typedef struct packed {
        logic                      en;
        logic [GLB_ADDR_WIDTH-1:0] addr;
        logic                      last;
    } rd_req_t;

endpackage

`default_nettype wire

// File: rtl/glb_hdr_fifo.sv
// ============================================================================
// glb_hdr_fifo : synchronous FIFO, type- and depth-parametrised (depth 2^n)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module glb_hdr_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  T                             i_data,
    input  logic                         i_pop,
    output T                             o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int c_pw = $clog2(DEPTH);
    localparam int c_cw = $clog2(DEPTH + 1);

    T                  r_mem [DEPTH];
    logic [c_pw-1:0]   r_wr_ptr;
    logic [c_pw-1:0]   r_rd_ptr;
    logic [c_cw-1:0]   r_count;
    logic              w_wr;
    logic              w_rd;

    assign w_rd    = i_pop && !o_empty;
    // A full FIFO may still take a write when the head leaves in the same cycle
    assign w_wr    = i_push && (!o_full || w_rd);
    assign o_full  = (r_count == c_cw'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_cw'(w_wr) - c_cw'(w_rd);
        end
    end

endmodule

`default_nettype wire

// File: rtl/glb_dma_hdr_agen.sv
// ============================================================================
// glb_dma_hdr_agen : DMA header queue + bank-word read address generator
// Optional beat counter output enabled by macro GLB_DMA_BEAT_CNT_EN
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module glb_dma_hdr_agen
    import glb_dma_hdr_agen_pkg::*;
#(
    parameter int QUEUE_DEPTH     = 4,
    parameter int ADDR_WIDTH      = GLB_ADDR_WIDTH,
    parameter int NUM_WORDS_WIDTH = MAX_NUM_WORDS_WIDTH,
    parameter int BANK_DATA_WIDTH = GLB_BANK_DATA_WIDTH,
    parameter int CGRA_DATA_WIDTH = GLB_CGRA_DATA_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               cfg_hdr_wr_en,
    input  dma_header_t                        cfg_hdr,
    output logic                               cfg_hdr_full,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   cfg_hdr_count,
    input  logic                               start_pulse,
    input  logic                               stall,
    output logic                               rd_req_en,
    output logic [ADDR_WIDTH-1:0]              rd_req_addr,
    output logic                               rd_req_last,
    output logic                               hdr_done_pulse,
    output logic                               queue_done_pulse,
    output logic                               busy,
    output logic                               err_overflow,
    input  logic                               clr_err
`ifdef GLB_DMA_BEAT_CNT_EN
    ,
    output logic [31:0]                        beat_cnt
`endif
);

    localparam int c_beat_bytes = BANK_DATA_WIDTH / 8;
    localparam int c_wpb        = BANK_DATA_WIDTH / CGRA_DATA_WIDTH;
    localparam int c_wpb_sh     = $clog2(c_wpb);
    localparam int c_bw         = NUM_WORDS_WIDTH + 1;

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_LOAD   = LOAD;
    localparam logic [1:0] S_STREAM = STREAM;
    localparam logic [1:0] S_NEXT   = NEXT;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic                    r_en;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_last;
    logic [c_bw-1:0]         r_remain;
    logic                    r_qd_idle;
    logic                    r_err;

    dma_header_t             w_head;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_push_req;
    logic                    w_push;
    logic                    w_overflow;
    logic                    w_accept;
    logic [c_bw-1:0]         w_beats;
    logic [ADDR_WIDTH-1:0]   w_head_addr;

    assign w_pop      = (r_state == S_LOAD);
    assign w_push_req = cfg_hdr_wr_en && cfg_hdr.valid;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_overflow = w_push_req && w_full && !w_pop;
    assign w_accept   = r_en && !stall;

    // Round up to whole beats; widened by one bit so the +3 cannot overflow
    assign w_beats     = (c_bw'(w_head.num_words) + c_bw'(c_wpb - 1)) >> c_wpb_sh;
    assign w_head_addr = ADDR_WIDTH'(w_head.start_addr) & ~ADDR_WIDTH'(c_beat_bytes - 1);

    glb_hdr_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .T     (dma_header_t)
    ) u_hdr_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_push),
        .i_data  (cfg_hdr),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (cfg_hdr_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_pulse && !w_empty) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = (w_beats == '0) ? S_NEXT : S_STREAM;
            end
            S_STREAM: begin
                if (w_accept && r_last) begin
                    w_state_nxt = S_NEXT;
                end
            end
            default: begin
                w_state_nxt = w_empty ? S_IDLE : S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_en      <= 1'b0;
            r_addr    <= '0;
            r_last    <= 1'b0;
            r_remain  <= '0;
            r_qd_idle <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_qd_idle <= (r_state == S_IDLE) && start_pulse && w_empty;

            // A same-cycle overflow takes priority over the clear
            if (w_overflow) begin
                r_err <= 1'b1;
            end else if (clr_err) begin
                r_err <= 1'b0;
            end

            case (r_state)
                S_LOAD: begin
                    r_remain <= w_beats;
                    r_en     <= (w_beats != '0);
                    r_last   <= (w_beats == c_bw'(1));
                    r_addr   <= (w_beats != '0) ? w_head_addr : '0;
                end
                S_STREAM: begin
                    if (w_accept) begin
                        if (r_last) begin
                            r_en   <= 1'b0;
                            r_last <= 1'b0;
                            r_addr <= '0;
                        end else begin
                            r_addr   <= r_addr + ADDR_WIDTH'(c_beat_bytes);
                            r_remain <= r_remain - 1'b1;
                            r_last   <= (r_remain == c_bw'(2));
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef GLB_DMA_BEAT_CNT_EN
    logic [31:0] r_beat_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_beat_cnt <= '0;
        end else if (clr_err) begin
            r_beat_cnt <= '0;
        end else if (w_accept && (r_beat_cnt != '1)) begin
            r_beat_cnt <= r_beat_cnt + 32'd1;
        end
    end

    assign beat_cnt = r_beat_cnt;
`endif

    assign cfg_hdr_full     = w_full;
    assign rd_req_en        = r_en;
    assign rd_req_addr      = r_addr;
    assign rd_req_last      = r_last;
    assign hdr_done_pulse   = (r_state == S_NEXT);
    assign queue_done_pulse = ((r_state == S_NEXT) && w_empty) || r_qd_idle;
    assign busy             = (r_state != S_IDLE);
    assign err_overflow     = r_err;

endmodule

`default_nettype wire
